sample_queue: RTL
=================

# sample_queue

Dual-channel (left/right) circular sample buffer feeding the equalizer FIR band filters. It stores incoming audio samples and, once it holds a full filter window, replays the newest TAPS samples oldest-to-newest on every new sample. During the replay it asserts `sequencing`, so the downstream filter can step its coefficient address and accumulate one tap per clock.

## Interface
- DEPTH, 1024: buffer entries per channel; power of two; DEPTH ≥ TAPS+2.
- TAPS, 1021: window length; number of samples replayed per burst.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- wrt_smpl  in  1  single-cycle strobe; lft_smpl/rght_smpl valid this cycle.
- lft_smpl  in  16  signed left sample.
- rght_smpl  in  16  signed right sample.
- lft_out  out  16  signed replayed left sample, registered.
- rght_out  out  16  signed replayed right sample, registered.
- sequencing  out  1  high for exactly TAPS consecutive cycles per burst; outputs valid while high.

## Operation
- Every wrt_smpl writes {lft_smpl, rght_smpl} at new_ptr, then new_ptr increments mod DEPTH. Writes are never blocked, including during a burst.
- occupancy counter: 0 at reset, +1 per write, saturates at TAPS.
- States: FILL, IDLE, READ.
  - FILL → IDLE when a write brings occupancy to TAPS. No burst is issued for that write.
  - IDLE: wrt_smpl → READ, burst start = write address − (TAPS−1) mod DEPTH.
  - READ issues TAPS sequential reads from the start address, wrapping mod DEPTH. After the last read it returns to IDLE, or restarts READ if pending is set.
- Correction to the FILL rule: the write that brings occupancy to TAPS does issue a burst. The FILL → IDLE transition and the burst start occur on that same write.
- wrt_smpl during READ: the sample is written and the single pending flag is set. The spare DEPTH−TAPS slots guarantee the active window is not overwritten. The pending burst starts the cycle after the current burst's last read, with its start computed at that moment (newest TAPS samples).
- Further wrt_smpl while pending is already set are written but merged into the one pending burst.
- Burst order: output k (k = 0..TAPS−1) is the k-th oldest sample in the window.
- Arithmetic: pointers are $clog2(DEPTH) bits with natural wrap. No arithmetic on sample data.

## Timing
- Reset values: lft_out = 0, rght_out = 0, sequencing = 0, state FILL, pointers 0, occupancy 0, pending 0.
- RAM has one-cycle synchronous read latency; the output stage registers one more cycle.
- wrt_smpl sampled in cycle N (burst-triggering) → first read address presented in N+1 → sequencing first high in N+2 with window sample 0 on the outputs.
- Burst is TAPS contiguous cycles. sequencing drops for at least one cycle between back-to-back bursts, so downstream sees a rising edge per burst.
- Outside bursts, lft_out/rght_out hold their last value.
- rst mid-burst: sequencing and the outputs clear immediately (asynchronously). State returns to FILL, buffer contents are logically discarded, and TAPS new samples are required before the next burst.
- wrt_smpl coincident with the last read cycle of a burst counts as arriving during READ, so the pending path is taken.

## Configuration
- SAMPLE_QUEUE_OVERRUN_EN defined: adds output `overrun` (1 bit, reset 0). It is sticky and set when wrt_smpl arrives while pending is already 1; only rst clears it.
- Not defined: no port; merged requests are silent.

## Structure
- Package queue_pkg: state enum (FILL, IDLE, READ), typedef smpl_t (logic signed [15:0]), default DEPTH/TAPS localparams.
- Sub-module queue_dpram: DEPTH×32 simple dual-port RAM, one write port, one registered read port. Instantiated once, with left and right samples packed as {lft, rght}.
- Top contains pointers, occupancy, FSM, pending flag and output registers.

## Test plan
- Reset: assert rst with random inputs → all outputs 0, no sequencing. Release → still 0.
- Fill: write samples lft=n, rght=−n for n=0..1020, spaced 50 cycles. No sequencing until write 1020. Burst starts 2 cycles later, lasts 1021 cycles, and outputs lft = 0..1020 in order.
- Steady state: write n=1021 → burst lft = 1..1021. Continue to n=1999, crossing the pointer wrap → last burst lft = 979..1999 in order.
- Mid-burst arrival: write n=2000 at burst cycle 500 and n=2001 at cycle 600. Current burst is unaffected. One extra burst starts after a 1-cycle gap with lft = 981..2001. overrun = 1 when SAMPLE_QUEUE_OVERRUN_EN is defined.
- Reset mid-burst: rst at burst cycle 300 → sequencing 0 the same cycle. 1020 new writes produce no burst; write 1021 produces a burst of the new data only.

Source files
------------

// File: rtl/sample_queue_pkg.sv
// Shared types and defaults for the sample_queue slice (package queue_pkg).
package queue_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        READ = 2'd2
    } state_t;

    typedef logic signed [15:0] smpl_t;

    localparam int unsigned DEPTH_DEF = 1024;
    localparam int unsigned TAPS_DEF  = 1021;

endpackage

// File: rtl/sample_queue_if.sv
// Sample-in / replay-out bundle between the sample source, sample_queue and the FIR.
// Optional SAMPLE_QUEUE_OVERRUN_EN adds the sticky overrun flag.
interface sample_queue_if;

    logic              wrt_smpl;
    queue_pkg::smpl_t  lft_smpl;
    queue_pkg::smpl_t  rght_smpl;
    queue_pkg::smpl_t  lft_out;
    queue_pkg::smpl_t  rght_out;
    logic              sequencing;
`ifdef SAMPLE_QUEUE_OVERRUN_EN
    logic              overrun;

    modport master (output wrt_smpl, lft_smpl, rght_smpl,
                    input  lft_out, rght_out, sequencing, overrun);
    modport slave  (input  wrt_smpl, lft_smpl, rght_smpl,
                    output lft_out, rght_out, sequencing, overrun);
`else
    modport master (output wrt_smpl, lft_smpl, rght_smpl,
                    input  lft_out, rght_out, sequencing);
    modport slave  (input  wrt_smpl, lft_smpl, rght_smpl,
                    output lft_out, rght_out, sequencing);
`endif

endinterface

// File: rtl/queue_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module queue_dpram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Registered read port; holds its last word when not enabled
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_queue.sv
// Dual-channel circular sample buffer replaying the newest TAPS samples per new sample.
// Optional feature macro: SAMPLE_QUEUE_OVERRUN_EN (sticky overrun output).
module sample_queue
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAPS  = TAPS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sample_queue_if.slave bus
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = $clog2(TAPS + 1);
    localparam logic [AW-1:0] SPAN = AW'(TAPS - 1);
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);
    localparam logic [CW-1:0] FULL = CW'(TAPS);

    state_t        state_q, state_d;
    logic [AW-1:0] new_ptr_q, new_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] newest, start;
    logic [31:0]   ram_dout;
    smpl_t         lft_q, rght_q;
    logic          seq_q;

    // Pointer, occupancy and burst sequencing next-state logic
    always_comb begin
        newest    = bus.wrt_smpl ? new_ptr_q : new_ptr_q - AW'(1);
        start     = newest - SPAN;
        state_d   = state_q;
        new_ptr_d = bus.wrt_smpl ? new_ptr_q + AW'(1) : new_ptr_q;
        occ_d     = (bus.wrt_smpl && occ_q != FULL) ? occ_q + CW'(1) : occ_q;
        rd_ptr_d  = rd_ptr_q;
        rcnt_d    = rcnt_q;
        pend_d    = pend_q;
        case (state_q)
            FILL: begin
                if (bus.wrt_smpl && occ_q == LAST) begin
                    state_d  = READ;
                    rd_ptr_d = start;
                    rcnt_d   = '0;
                end
            end
            IDLE: begin
                if (bus.wrt_smpl || pend_q) begin
                    state_d  = READ;
                    rd_ptr_d = start;
                    rcnt_d   = '0;
                    pend_d   = 1'b0;
                end
            end
            READ: begin
                pend_d = pend_q | bus.wrt_smpl;
                if (rcnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    rcnt_d   = rcnt_q + CW'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            new_ptr_q <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rcnt_q    <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_ptr_q <= new_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rcnt_q    <= rcnt_d;
            pend_q    <= pend_d;
        end
    end

    // The RAM is addressed with the next-state read pointer so its word for
    // rd_ptr_q is already present while state_q is READ; the output stage then
    // adds its register and the burst appears two cycles after the trigger.
    queue_dpram #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (bus.wrt_smpl),
        .waddr_i (new_ptr_q),
        .wdata_i ({bus.lft_smpl, bus.rght_smpl}),
        .re_i    (state_d == READ),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_dout)
    );

    // Output stage: capture each replayed word, hold between bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
            seq_q  <= 1'b0;
        end else begin
            seq_q <= (state_q == READ);
            if (state_q == READ) begin
                lft_q  <= ram_dout[31:16];
                rght_q <= ram_dout[15:0];
            end
        end
    end

    assign bus.lft_out    = lft_q;
    assign bus.rght_out   = rght_q;
    assign bus.sequencing = seq_q;

`ifdef SAMPLE_QUEUE_OVERRUN_EN
    logic ovr_q;

    // Sticky flag: a request arrived while one was already pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_q <= 1'b0;
        else     ovr_q <= ovr_q | (bus.wrt_smpl & pend_q);
    end

    assign bus.overrun = ovr_q;
`endif

endmodule
